slave_sync_tracker: RTL and testbench
=====================================

# slave_sync_tracker

Slave-side timing tracker that consumes the access-code correlator sync pulse and measures its arrival phase against the local slave 1 µs slot counter. It filters the phase error and issues signed microsecond adjust requests to the slave timebase slot offset. It also runs link supervision and raises a lost-sync event when no valid sync is accepted for a programmable number of slots. It sits between the correlator and the slave clock generator, closing the loop that the slave clock generator opens.

## Interface
Parameters:
- SLOT_US, 625, slot length in µs; the 1 µs counter runs 0..SLOT_US-1.
- OUTLIER_MAX, 3, consecutive out-of-tolerance syncs that force re-acquisition.

Ports:
- clk_6M  in  1  6 MHz system clock; single clock domain.
- rst  in  1  asynchronous, active-high reset.
- enable  in  1  tracking enable; low forces IDLE.
- p_1us  in  1  1 µs strobe, one clk_6M cycle wide.
- s_tslot_p  in  1  slave slot-boundary pulse.
- s_counter_1us  in  10  slave µs counter within the slot, 0..624.
- CLK_slave  in  28  slave piconet clock.
- corre_sync_p  in  1  sync-word correlation pulse.
- regi_expected_sync_us  in  10  nominal s_counter_1us value at sync.
- regi_err_tol  in  6  accepted |error| in µs while tracking.
- regi_avg_shift  in  2  loop gain: adjust = error >>> shift.
- regi_lost_slots  in  12  supervision timeout in slots; 0 disables supervision.
- sync_err  out  11  signed, last measured error in µs.
- adj_p  out  1  one-cycle adjust request.
- adj_us  out  10  signed adjust value, valid with adj_p.
- locked  out  1  high in TRACK.
- sync_lost_p  out  1  one-cycle supervision-timeout pulse.
- slots_since_sync  out  12  slots since the last accepted sync.
- last_sync_CLK  out  26  CLK_slave[27:2] at the last accepted sync.

## Operation
- States: IDLE, ACQ, TRACK, LOST.
  - IDLE -> ACQ when enable=1.
  - Any state -> IDLE when enable=0; this clears counters and the outlier count.
- Error computation:
  - raw = s_counter_1us - regi_expected_sync_us, 11-bit signed.
  - If raw > 312, subtract 625. If raw < -312, add 625. The result lies in -312..+312.
- ACQ or LOST, on sync:
  - sync is accepted unconditionally.
  - adj_us = full error.
  - Go to TRACK.
- TRACK, on sync:
  - If |err| > regi_err_tol, the sync is an outlier. No adjust is issued, the sync is not accepted, and outlier_cnt increments.
  - When outlier_cnt reaches OUTLIER_MAX, go to ACQ.
  - Otherwise the sync is accepted and outlier_cnt clears.
  - adj_us = err >>> regi_avg_shift. If that result is 0 and err != 0, adj_us = sign(err) (±1).
  - err = 0 means the sync is accepted with no adj_p.
- Every accepted sync:
  - Clears slots_since_sync.
  - Latches last_sync_CLK.
- Supervision:
  - slots_since_sync increments on s_tslot_p and saturates at 4095.
  - In ACQ or TRACK, when regi_lost_slots != 0 and the count reaches regi_lost_slots, pulse sync_lost_p once and go to LOST.
  - LOST holds until a sync arrives or enable=0.
- Simultaneous accepted sync and s_tslot_p: the clear wins and the counter becomes 0.
- corre_sync_p in IDLE is ignored.

## Timing
- Cycle N samples corre_sync_p.
- N+1: sync_err is registered; the accept/outlier decision is made.
- N+2: adj_p and adj_us are presented; state, last_sync_CLK, outlier_cnt and slots_since_sync update.
- A sync arriving while a previous one is in flight (N+1) is dropped.
- sync_lost_p is asserted the cycle after the s_tslot_p that reaches the threshold.
- Reset values:
  - state IDLE
  - sync_err 0, adj_p 0, adj_us 0
  - locked 0, sync_lost_p 0
  - slots_since_sync 0, last_sync_CLK 0
- rst asserted mid-operation drops any in-flight sync; no adj_p is emitted after reset release.
- regi_* inputs are sampled at use; changing them mid-slot is allowed.

## Structure
- Package slave_sync_pkg holds:
  - the state enum
  - SLOT_US and HALF_SLOT_US (312)
  - error width 11 and adjust width 10
- One sub-module, slot_supervisor, contains the slot counter, saturation, timeout compare and sync_lost_p. The core tracker keeps the FSM, error pipeline and filter.

## Test plan
- Acquisition and wrap: enable, expected=68, sync at counter 70 -> adj_us=+2 at N+2, locked=1. Sync at counter 620 -> err = 552 - 625 = -73.
- Tracking gain: tol=10, shift=2, err=+9 -> adj_us=+2. Then err=+1 -> adj_us=+1. Then err=0 -> no adj_p, slots_since_sync cleared.
- Outliers: tol=5, errors +40, -50, +60 -> no adj_p on any. After the third, locked=0 (ACQ). The next err=+7 -> adj_us=+7.
- Supervision: regi_lost_slots=4, no syncs -> sync_lost_p one cycle after the 4th s_tslot_p, state LOST. A later sync -> TRACK. With regi_lost_slots=0, never lost.
- Simultaneity: s_tslot_p and accepted sync in the same slot cycle -> slots_since_sync=0. last_sync_CLK equals CLK_slave[27:2] at the sync cycle.
- Reset and enable: rst asserted at N+1 of a sync -> no adj_p, all outputs zero. enable dropped in TRACK -> IDLE; a subsequent sync is ignored.

Source files
------------

// File: rtl/slave_sync_pkg.sv
// Shared types and constants for the slave sync tracker: FSM states, slot
// geometry and datapath widths.
package slave_sync_pkg;

  localparam int SLOT_US      = 625;
  localparam int HALF_SLOT_US = 312;
  localparam int ERR_W        = 11;
  localparam int ADJ_W        = 10;
  localparam int SLOT_CNT_W   = 12;
  localparam int CLK_W        = 28;
  localparam int SYNC_CLK_W   = 26;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACQ   = 2'd1,
    ST_TRACK = 2'd2,
    ST_LOST  = 2'd3
  } state_t;

endpackage

// File: rtl/slot_supervisor.sv
// Link supervision: counts slots since the last accepted sync (saturating)
// and flags a timeout when the programmed slot budget is reached.
module slot_supervisor
  import slave_sync_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  tslot_p,
  input  logic                  arm,
  input  logic [SLOT_CNT_W-1:0] lost_slots,
  output logic [SLOT_CNT_W-1:0] count,
  output logic                  timeout,
  output logic                  lost_p
);

  localparam logic [SLOT_CNT_W-1:0] CNT_MAX = '1;

  logic [SLOT_CNT_W-1:0] count_nxt;

  // A clear on the same cycle as a slot boundary wins.
  always_comb begin
    count_nxt = count;
    if (clr)
      count_nxt = '0;
    else if (tslot_p && count != CNT_MAX)
      count_nxt = count + 1'b1;
  end

  // >= rather than == so a count already past a lowered threshold still trips.
  assign timeout = tslot_p && !clr && arm && (lost_slots != '0) &&
                   (count_nxt >= lost_slots);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count  <= '0;
      lost_p <= 1'b0;
    end else begin
      count  <= count_nxt;
      lost_p <= timeout;
    end
  end

endmodule

// File: rtl/slave_sync_tracker.sv
// Slave sync tracker: measures correlator sync phase against the local slot
// counter, filters it into timebase adjust requests and supervises the link.
module slave_sync_tracker #(
  parameter int SLOT_US     = 625,
  parameter int OUTLIER_MAX = 3
) (
  input  logic                                     clk_6M,
  input  logic                                     rst,
  input  logic                                     enable,
  input  logic                                     p_1us,
  input  logic                                     s_tslot_p,
  input  logic [9:0]                               s_counter_1us,
  input  logic [slave_sync_pkg::CLK_W-1:0]         CLK_slave,
  input  logic                                     corre_sync_p,
  input  logic [9:0]                               regi_expected_sync_us,
  input  logic [5:0]                               regi_err_tol,
  input  logic [1:0]                               regi_avg_shift,
  input  logic [slave_sync_pkg::SLOT_CNT_W-1:0]    regi_lost_slots,
  output logic signed [slave_sync_pkg::ERR_W-1:0]  sync_err,
  output logic                                     adj_p,
  output logic signed [slave_sync_pkg::ADJ_W-1:0]  adj_us,
  output logic                                     locked,
  output logic                                     sync_lost_p,
  output logic [slave_sync_pkg::SLOT_CNT_W-1:0]    slots_since_sync,
  output logic [slave_sync_pkg::SYNC_CLK_W-1:0]    last_sync_CLK
);

  import slave_sync_pkg::*;

  localparam int OCW = $clog2(OUTLIER_MAX + 1);
  localparam logic signed [ERR_W:0] SLOT_S = (ERR_W+1)'(SLOT_US);
  localparam logic signed [ERR_W:0] HALF_S = (ERR_W+1)'(SLOT_US / 2);
  localparam logic [OCW-1:0]        OUT_LAST = OCW'(OUTLIER_MAX - 1);

  state_t                  state;
  logic                    sync_vld;
  logic [SYNC_CLK_W-1:0]   sync_clk;
  logic [OCW-1:0]          outlier_cnt;

  logic signed [ERR_W:0]   raw, wrapped;
  logic signed [ERR_W-1:0] err_in, err_shr, trk_adj;
  logic [ERR_W-1:0]        err_abs;
  logic                    take, outlier, accept, arm, sup_clr, timeout;
  logic                    unused_ok;

  assign unused_ok = ^{p_1us, CLK_slave[1:0]};

  // Phase error folded into one half-slot either side of nominal.
  always_comb begin
    raw     = $signed({2'b00, s_counter_1us}) - $signed({2'b00, regi_expected_sync_us});
    wrapped = raw;
    if (raw > HALF_S)
      wrapped = raw - SLOT_S;
    else if (raw < -HALF_S)
      wrapped = raw + SLOT_S;
    err_in = wrapped[ERR_W-1:0];
  end

  // A sync is only taken when tracking is live and no earlier one is in flight.
  assign take = enable && (state != ST_IDLE) && corre_sync_p && !sync_vld;

  always_comb begin
    err_abs = sync_err[ERR_W-1] ? ERR_W'(-sync_err) : ERR_W'(sync_err);
    err_shr = sync_err >>> regi_avg_shift;
    trk_adj = err_shr;
    // Small errors must still nudge the timebase, or the loop stalls short of zero.
    if (err_shr == '0 && sync_err != '0)
      trk_adj = sync_err[ERR_W-1] ? -ERR_W'(1) : ERR_W'(1);
  end

  assign outlier = (state == ST_TRACK) && (err_abs > {{(ERR_W-6){1'b0}}, regi_err_tol});
  assign accept  = enable && sync_vld &&
                   ((state == ST_ACQ) || (state == ST_LOST) ||
                    ((state == ST_TRACK) && !outlier));
  assign arm     = enable && ((state == ST_ACQ) || (state == ST_TRACK));
  assign sup_clr = accept || !enable || (state == ST_IDLE);

  slot_supervisor u_sup (
    .clk        (clk_6M),
    .rst        (rst),
    .clr        (sup_clr),
    .tslot_p    (s_tslot_p),
    .arm        (arm),
    .lost_slots (regi_lost_slots),
    .count      (slots_since_sync),
    .timeout    (timeout),
    .lost_p     (sync_lost_p)
  );

  always_ff @(posedge clk_6M or posedge rst) begin
    if (rst) begin
      state         <= ST_IDLE;
      sync_vld      <= 1'b0;
      sync_clk      <= '0;
      sync_err      <= '0;
      adj_p         <= 1'b0;
      adj_us        <= '0;
      locked        <= 1'b0;
      last_sync_CLK <= '0;
      outlier_cnt   <= '0;
    end else begin
      adj_p    <= 1'b0;
      sync_vld <= take;
      if (take) begin
        sync_err <= err_in;
        sync_clk <= CLK_slave[CLK_W-1:2];
      end
      if (accept)
        last_sync_CLK <= sync_clk;

      if (!enable) begin
        state       <= ST_IDLE;
        locked      <= 1'b0;
        outlier_cnt <= '0;
      end else begin
        case (state)
          ST_IDLE: state <= ST_ACQ;

          ST_ACQ, ST_LOST: begin
            if (accept) begin
              state       <= ST_TRACK;
              locked      <= 1'b1;
              outlier_cnt <= '0;
              adj_p       <= 1'b1;
              adj_us      <= sync_err[ADJ_W-1:0];
            end else if (timeout) begin
              state <= ST_LOST;
            end
          end

          ST_TRACK: begin
            if (accept) begin
              outlier_cnt <= '0;
              if (sync_err != '0) begin
                adj_p  <= 1'b1;
                adj_us <= trk_adj[ADJ_W-1:0];
              end
            end else if (timeout) begin
              state       <= ST_LOST;
              locked      <= 1'b0;
              outlier_cnt <= '0;
            end else if (sync_vld) begin
              if (outlier_cnt == OUT_LAST) begin
                state       <= ST_ACQ;
                locked      <= 1'b0;
                outlier_cnt <= '0;
              end else begin
                outlier_cnt <= outlier_cnt + 1'b1;
              end
            end
          end

          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_slave_sync_tracker.sv
// Directed self-checking bench for slave_sync_tracker.
module tb_slave_sync_tracker;

  logic               clk_6M = 1'b0;
  logic               rst;
  logic               enable;
  logic               p_1us;
  logic               s_tslot_p;
  logic [9:0]         s_counter_1us;
  logic [27:0]        CLK_slave;
  logic               corre_sync_p;
  logic [9:0]         regi_expected_sync_us;
  logic [5:0]         regi_err_tol;
  logic [1:0]         regi_avg_shift;
  logic [11:0]        regi_lost_slots;
  logic signed [10:0] sync_err;
  logic               adj_p;
  logic signed [9:0]  adj_us;
  logic               locked;
  logic               sync_lost_p;
  logic [11:0]        slots_since_sync;
  logic [25:0]        last_sync_CLK;

  int n_assert = 0;
  int n_fail   = 0;
  logic seen;

  slave_sync_tracker #(.SLOT_US(625), .OUTLIER_MAX(3)) dut (
    .clk_6M                (clk_6M),
    .rst                   (rst),
    .enable                (enable),
    .p_1us                 (p_1us),
    .s_tslot_p             (s_tslot_p),
    .s_counter_1us         (s_counter_1us),
    .CLK_slave             (CLK_slave),
    .corre_sync_p          (corre_sync_p),
    .regi_expected_sync_us (regi_expected_sync_us),
    .regi_err_tol          (regi_err_tol),
    .regi_avg_shift        (regi_avg_shift),
    .regi_lost_slots       (regi_lost_slots),
    .sync_err              (sync_err),
    .adj_p                 (adj_p),
    .adj_us                (adj_us),
    .locked                (locked),
    .sync_lost_p           (sync_lost_p),
    .slots_since_sync      (slots_since_sync),
    .last_sync_CLK         (last_sync_CLK)
  );

  always #5 clk_6M = ~clk_6M;

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk_6M);
    #1;
  endtask

  // Sync sampled at edge N; returns #1 after edge N+1 (outputs of N+2 visible).
  task automatic do_sync(input logic [9:0] cnt, input logic [25:0] cv, input logic tslot_n1);
    s_counter_1us = cnt;
    CLK_slave     = {cv, 2'b10};
    corre_sync_p  = 1'b1;
    tick(1);
    corre_sync_p  = 1'b0;
    CLK_slave     = ~CLK_slave;
    s_tslot_p     = tslot_n1;
    tick(1);
    s_tslot_p     = 1'b0;
  endtask

  task automatic pulse_slot();
    s_tslot_p = 1'b1;
    tick(1);
    s_tslot_p = 1'b0;
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; p_1us = 1'b0; s_tslot_p = 1'b0;
    s_counter_1us = '0; CLK_slave = '0; corre_sync_p = 1'b0;
    regi_expected_sync_us = 10'd68; regi_err_tol = 6'd10;
    regi_avg_shift = 2'd2; regi_lost_slots = 12'd0;
    tick(3);
    chk("rst_sync_err", sync_err, 0);
    chk("rst_adj_p", adj_p, 0);
    chk("rst_adj_us", adj_us, 0);
    chk("rst_locked", locked, 0);
    chk("rst_lost_p", sync_lost_p, 0);
    chk("rst_slots", slots_since_sync, 0);
    chk("rst_last_clk", last_sync_CLK, 0);

    rst = 1'b0; enable = 1'b1;
    tick(2);
    // Acquisition: err +2 applied in full
    do_sync(10'd70, 26'h0000123, 1'b0);
    chk("acq_adj_p", adj_p, 1);
    chk("acq_adj_us", $signed(adj_us), 2);
    chk("acq_locked", locked, 1);
    chk("acq_err", sync_err, 2);
    chk("acq_last_clk", last_sync_CLK, 26'h0000123);
    tick(1);
    chk("acq_adj_p_1cyc", adj_p, 0);

    enable = 1'b0; tick(1);
    chk("en_drop_unlock", locked, 0);
    enable = 1'b1; tick(2);
    // Wrap: 620-68 = 552 -> -73
    do_sync(10'd620, 26'h0000200, 1'b0);
    chk("wrap_err", sync_err, -73);
    chk("wrap_adj_us", $signed(adj_us), -73);
    chk("wrap_locked", locked, 1);

    // Tracking gain (tol 10, shift 2)
    do_sync(10'd77, 26'h0000300, 1'b0);
    chk("trk9_adj_p", adj_p, 1);
    chk("trk9_adj_us", $signed(adj_us), 2);
    do_sync(10'd69, 26'h0000310, 1'b0);
    chk("trk1_adj_p", adj_p, 1);
    chk("trk1_adj_us", $signed(adj_us), 1);
    pulse_slot(); tick(1); pulse_slot(); tick(1);
    chk("trk_slots2", slots_since_sync, 2);
    do_sync(10'd68, 26'h0000320, 1'b0);
    chk("trk0_adj_p", adj_p, 0);
    chk("trk0_slots", slots_since_sync, 0);
    chk("trk0_last_clk", last_sync_CLK, 26'h0000320);

    // Outliers (tol 5)
    regi_err_tol = 6'd5;
    do_sync(10'd108, 26'h00000A1, 1'b0);
    chk("out1_adj_p", adj_p, 0);
    chk("out1_locked", locked, 1);
    chk("out1_last_clk", last_sync_CLK, 26'h0000320);
    do_sync(10'd18, 26'h00000A2, 1'b0);
    chk("out2_err", sync_err, -50);
    chk("out2_adj_p", adj_p, 0);
    chk("out2_locked", locked, 1);
    do_sync(10'd128, 26'h00000A3, 1'b0);
    chk("out3_adj_p", adj_p, 0);
    chk("out3_locked", locked, 0);
    do_sync(10'd75, 26'h00000A4, 1'b0);
    chk("reacq_adj_p", adj_p, 1);
    chk("reacq_adj_us", $signed(adj_us), 7);
    chk("reacq_locked", locked, 1);

    // Supervision: timeout after 4 slots
    regi_lost_slots = 12'd4;
    pulse_slot(); tick(1); pulse_slot(); tick(1); pulse_slot();
    chk("sup3_lost_p", sync_lost_p, 0);
    chk("sup3_locked", locked, 1);
    tick(1);
    pulse_slot();
    chk("sup4_lost_p", sync_lost_p, 1);
    chk("sup4_locked", locked, 0);
    chk("sup4_slots", slots_since_sync, 4);
    tick(1);
    chk("sup4_lost_p_1cyc", sync_lost_p, 0);
    do_sync(10'd70, 26'h0000400, 1'b0);
    chk("lost_resync_adj", $signed(adj_us), 2);
    chk("lost_resync_locked", locked, 1);

    regi_lost_slots = 12'd0;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      pulse_slot();
      if (sync_lost_p) seen = 1'b1;
      tick(1);
    end
    chk("nosup_lost_seen", seen, 0);
    chk("nosup_locked", locked, 1);
    chk("nosup_slots", slots_since_sync, 6);

    // Accepted sync and slot boundary on the same cycle
    do_sync(10'd69, 26'h0ABCDEF, 1'b1);
    chk("simul_slots", slots_since_sync, 0);
    chk("simul_last_clk", last_sync_CLK, 26'h0ABCDEF);
    chk("simul_adj_us", $signed(adj_us), 1);

    // Reset with a sync in flight
    tick(2);
    s_counter_1us = 10'd80; corre_sync_p = 1'b1;
    tick(1);
    corre_sync_p = 1'b0; rst = 1'b1;
    #1;
    chk("rstmid_adj_p", adj_p, 0);
    tick(2);
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick(1);
      if (adj_p !== 1'b0) seen = 1'b1;
    end
    chk("rstmid_no_adj", seen, 0);
    chk("rstmid_err", sync_err, 0);
    chk("rstmid_adj_us", adj_us, 0);
    chk("rstmid_last_clk", last_sync_CLK, 0);
    chk("rstmid_slots", slots_since_sync, 0);

    // Enable drop in TRACK; later syncs ignored
    do_sync(10'd70, 26'h0000500, 1'b0);
    chk("en_lock", locked, 1);
    enable = 1'b0; tick(1);
    chk("en_off_locked", locked, 0);
    s_counter_1us = 10'd90; corre_sync_p = 1'b1;
    tick(1);
    corre_sync_p = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      if (adj_p !== 1'b0) seen = 1'b1;
    end
    chk("idle_ignored_adj", seen, 0);
    chk("idle_ignored_err", sync_err, 2);
    chk("idle_last_clk", last_sync_CLK, 26'h0000500);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
